// File: rtl/add_sub_exp_align.sv
// add_sub_exp_align: FPU add/sub front end; orders operands by magnitude and aligns the smaller mantissa.
// Optional NaN/Inf flag pipeline built when ADD_SUB_ALIGN_SPECIAL_EN is defined.
module add_sub_exp_align #(
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_MAN  = 23,
    parameter int SIZE_DATA = 1 + SIZE_EXP + SIZE_MAN
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [SIZE_DATA-1:0]  i_data_a,
    input  logic [SIZE_DATA-1:0]  i_data_b,
    input  logic                  i_sub,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SIZE_EXP-1:0]   o_exp_common,
    output logic [SIZE_EXP-1:0]   o_exp_diff,
    output logic [SIZE_MAN+3:0]   o_man_large,
    output logic [SIZE_MAN+3:0]   o_man_small,
    output logic                  o_sign_large,
    output logic                  o_eff_sub,
    output logic                  o_swap,
    output logic [1:0]            o_special
);
    localparam int MW = SIZE_MAN + 4;

    logic s1_v, s2_v, s1_en, s2_en;
    assign s2_en   = i_ready | ~s2_v;
    assign s1_en   = s2_en | ~s1_v;
    assign o_ready = s1_en & i_rst_n;
    assign o_valid = s2_v;

    logic [SIZE_EXP-1:0] exp_a, exp_b, eexp_a, eexp_b;
    logic [SIZE_MAN-1:0] frac_a, frac_b;
    logic [SIZE_MAN:0]   man_a, man_b;
    logic                sign_b, swap, eff_sub;
    assign exp_a   = i_data_a[SIZE_DATA-2 -: SIZE_EXP];
    assign exp_b   = i_data_b[SIZE_DATA-2 -: SIZE_EXP];
    assign frac_a  = i_data_a[SIZE_MAN-1:0];
    assign frac_b  = i_data_b[SIZE_MAN-1:0];
    assign eexp_a  = (exp_a == '0) ? SIZE_EXP'(1) : exp_a;
    assign eexp_b  = (exp_b == '0) ? SIZE_EXP'(1) : exp_b;
    assign man_a   = {|exp_a, frac_a};
    assign man_b   = {|exp_b, frac_b};
    assign sign_b  = i_data_b[SIZE_DATA-1] ^ i_sub;
    // raw {exp, fraction} compare orders denormals correctly too
    assign swap    = i_data_b[SIZE_DATA-2:0] > i_data_a[SIZE_DATA-2:0];
    assign eff_sub = i_data_a[SIZE_DATA-1] ^ sign_b;

    logic [SIZE_EXP-1:0] s1_exp, s1_diff;
    logic [SIZE_MAN:0]   s1_man_large, s1_man_small;
    logic                s1_sign, s1_eff_sub, s1_swap;

    logic [SIZE_EXP-1:0] shamt;
    logic [MW-1:0]       full, shifted, man_small_sh;
    logic                lost;
    assign shamt        = (s1_diff > SIZE_EXP'(MW)) ? SIZE_EXP'(MW) : s1_diff;
    assign full         = {s1_man_small, 3'b000};
    assign shifted      = full >> shamt;
    assign lost         = |(full & ~({MW{1'b1}} << shamt));
    assign man_small_sh = {shifted[MW-1:1], shifted[0] | lost};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_v         <= 1'b0;
            s1_exp       <= '0;
            s1_diff      <= '0;
            s1_man_large <= '0;
            s1_man_small <= '0;
            s1_sign      <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s1_swap      <= 1'b0;
            s2_v         <= 1'b0;
            o_exp_common <= '0;
            o_exp_diff   <= '0;
            o_man_large  <= '0;
            o_man_small  <= '0;
            o_sign_large <= 1'b0;
            o_eff_sub    <= 1'b0;
            o_swap       <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_v         <= i_valid;
                s1_exp       <= swap ? eexp_b : eexp_a;
                s1_diff      <= swap ? eexp_b - eexp_a : eexp_a - eexp_b;
                s1_man_large <= swap ? man_b : man_a;
                s1_man_small <= swap ? man_a : man_b;
                s1_sign      <= swap ? sign_b : i_data_a[SIZE_DATA-1];
                s1_eff_sub   <= eff_sub;
                s1_swap      <= swap;
            end
            if (s2_en) begin
                s2_v         <= s1_v;
                o_exp_common <= s1_exp;
                o_exp_diff   <= s1_diff;
                o_man_large  <= {s1_man_large, 3'b000};
                o_man_small  <= man_small_sh;
                o_sign_large <= s1_sign;
                o_eff_sub    <= s1_eff_sub;
                o_swap       <= s1_swap;
            end
        end
    end

`ifdef ADD_SUB_ALIGN_SPECIAL_EN
    logic inf_a, inf_b, nan, inf;
    logic [1:0] s1_special;
    assign inf_a = (&exp_a) & ~(|frac_a);
    assign inf_b = (&exp_b) & ~(|frac_b);
    assign nan   = ((&exp_a) & (|frac_a)) | ((&exp_b) & (|frac_b)) | (inf_a & inf_b & eff_sub);
    assign inf   = (inf_a | inf_b) & ~nan;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_special <= 2'b00;
            o_special  <= 2'b00;
        end else begin
            if (s1_en) s1_special <= {nan, inf};
            if (s2_en) o_special <= s1_special;
        end
    end
`else
    assign o_special = 2'b00;
`endif
endmodule

// File: tb/tb_add_sub_exp_align.sv
// tb_add_sub_exp_align: directed plan vectors plus randomized traffic scored against an arithmetic model.
module tb_add_sub_exp_align;
    logic        i_clk = 1'b0;
    logic        i_rst_n, i_valid, i_ready, i_sub;
    logic [31:0] i_data_a, i_data_b;
    logic        o_ready, o_valid, o_sign_large, o_eff_sub, o_swap;
    logic [7:0]  o_exp_common, o_exp_diff;
    logic [26:0] o_man_large, o_man_small;
    logic [1:0]  o_special;

    int checks = 0;
    int errors = 0;

    add_sub_exp_align dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_sub(i_sub),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_exp_common(o_exp_common), .o_exp_diff(o_exp_diff),
        .o_man_large(o_man_large), .o_man_small(o_man_small),
        .o_sign_large(o_sign_large), .o_eff_sub(o_eff_sub), .o_swap(o_swap),
        .o_special(o_special)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0]  ec, ed;
        logic [26:0] ml, ms;
        logic        sl, es, sw;
        logic [1:0]  sp;
    } res_t;

    logic [74:0] outs;
    assign outs = {o_exp_common, o_exp_diff, o_man_large, o_man_small,
                   o_sign_large, o_eff_sub, o_swap, o_special};

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        res_t r;
        int xa, xb, xl, xs, sh;
        longint ma, mb, full, q, rem;
        logic nan_a, nan_b, inf_a, inf_b, nan;
        xa = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        xb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        ma = longint'(a[22:0]) + ((a[30:23] != 0) ? 64'd8388608 : 64'd0);
        mb = longint'(b[22:0]) + ((b[30:23] != 0) ? 64'd8388608 : 64'd0);
        r.sw = (xb > xa) || (xb == xa && mb > ma);
        xl = r.sw ? xb : xa;
        xs = r.sw ? xa : xb;
        r.ec = 8'(xl);
        r.ed = 8'(xl - xs);
        r.ml = 27'((r.sw ? mb : ma) * 8);
        full = (r.sw ? ma : mb) * 8;
        sh = (xl - xs > 27) ? 27 : xl - xs;
        q = full / (64'd1 << sh);
        rem = full - q * (64'd1 << sh);
        r.ms = 27'(q) | 27'(rem != 0);
        r.es = a[31] ^ b[31] ^ sub;
        r.sl = r.sw ? (b[31] ^ sub) : a[31];
        nan_a = a[30:23] == 8'hFF && a[22:0] != 0;
        nan_b = b[30:23] == 8'hFF && b[22:0] != 0;
        inf_a = a[30:23] == 8'hFF && a[22:0] == 0;
        inf_b = b[30:23] == 8'hFF && b[22:0] == 0;
        nan = nan_a || nan_b || (inf_a && inf_b && r.es);
`ifdef ADD_SUB_ALIGN_SPECIAL_EN
        r.sp = {nan, (inf_a || inf_b) && !nan};
`else
        r.sp = 2'b00;
`endif
        return r;
    endfunction

    res_t q_exp[$];
    logic prev_stall = 1'b0;
    logic [74:0] prev_out;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            q_exp.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && o_valid) check("hold_stable", outs, prev_out);
            if (o_valid && i_ready) begin
                if (q_exp.size() == 0) check("spurious_valid", o_valid, 0);
                else check("scoreboard", outs, q_exp.pop_front());
            end
            if (i_valid && o_ready) q_exp.push_back(model(i_data_a, i_data_b, i_sub));
            prev_stall = o_valid && !i_ready;
            prev_out = outs;
        end
    end

    // call at posedge+1; returns at posedge+1 after the accepting edge with i_valid low
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int n = 0;
        i_valid = 1'b1;
        i_data_a = a;
        i_data_b = b;
        i_sub = sub;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", o_ready, 1);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic run_dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input res_t e);
        send(a, b, sub);
        repeat (2) @(negedge i_clk);
        check({tag, "_valid"}, o_valid, 1);
        check({tag, "_ec"}, o_exp_common, e.ec);
        check({tag, "_ed"}, o_exp_diff, e.ed);
        check({tag, "_ml"}, o_man_large, e.ml);
        check({tag, "_ms"}, o_man_small, e.ms);
        check({tag, "_flags"}, {o_sign_large, o_eff_sub, o_swap}, {e.sl, e.es, e.sw});
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] gen_b(input logic [31:0] a);
        logic [31:0] b = $urandom;
        case ($urandom_range(0, 5))
            1: b[30:23] = a[30:23];
            2: b[30:23] = a[30:23] + 8'($urandom_range(0, 40)) - 8'd20;
            3: b[30:0] = '0;
            4: begin b[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) b[22:0] = '0; end
            5: b[30:23] = 8'h00;
            default: ;
        endcase
        return b;
    endfunction

    logic [1:0] sp_exp;
    bit done;

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_sub = 1'b0;
        i_data_a = '0; i_data_b = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 0);
        check("rst_outs", outs, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        run_dir("t1", 32'h3F800000, 32'h3F000000, 1'b0,
                '{ec: 8'h7F, ed: 8'd1, ml: 27'h4000000, ms: 27'h2000000, sl: 0, es: 0, sw: 0, sp: 0});
        run_dir("t2", 32'h3F000000, 32'h40000000, 1'b0,
                '{ec: 8'h80, ed: 8'd2, ml: 27'h4000000, ms: 27'h1000000, sl: 0, es: 0, sw: 1, sp: 0});
        run_dir("t3", 32'h3F800000, 32'h30800000, 1'b0,
                '{ec: 8'h7F, ed: 8'd30, ml: 27'h4000000, ms: 27'h0000001, sl: 0, es: 0, sw: 0, sp: 0});
        run_dir("t4", 32'h3F800000, 32'h3FC00000, 1'b1,
                '{ec: 8'h7F, ed: 8'd0, ml: 27'h6000000, ms: 27'h4000000, sl: 1, es: 1, sw: 1, sp: 0});

`ifdef ADD_SUB_ALIGN_SPECIAL_EN
        sp_exp = 2'b10;
`else
        sp_exp = 2'b00;
`endif
        send(32'h7F800000, 32'h7F800000, 1'b1);
        repeat (2) @(negedge i_clk);
        check("inf_minus_inf", o_special, sp_exp);
        @(posedge i_clk);
        #1;

        // backpressure: both stages fill, o_ready drops, results emerge in order
        i_ready = 1'b0;
        fork
            begin
                send(32'h3F800000, 32'h3F000000, 1'b0);
                send(32'h40400000, 32'hC0000000, 1'b1);
                send(32'h00000000, 32'h80000000, 1'b0);
                send(32'h00400000, 32'h3F800000, 1'b1);
            end
            begin
                repeat (4) @(negedge i_clk);
                check("stall_ready", o_ready, 0);
                check("stall_valid", o_valid, 1);
                @(posedge i_clk);
                #1;
                i_ready = 1'b1;
            end
        join
        repeat (4) @(posedge i_clk);
        #1;

        // reset with two ops in flight
        send(32'h41200000, 32'h3DCCCCCD, 1'b0);
        send(32'hC1200000, 32'h3DCCCCCD, 1'b1);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check("flush_valid", o_valid, 0);
        check("flush_outs", outs, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        run_dir("post_rst", 32'h3F800000, 32'h3F000000, 1'b0,
                '{ec: 8'h7F, ed: 8'd1, ml: 27'h4000000, ms: 27'h2000000, sl: 0, es: 0, sw: 0, sp: 0});

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [31:0] a;
                    a = $urandom;
                    if ($urandom_range(0, 7) == 0) a[30:0] = '0;
                    send(a, gen_b(a), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge i_clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge i_clk);
                    #1;
                    i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        i_ready = 1'b1;
        for (int n = 0; n < 100 && q_exp.size() != 0; n++) @(posedge i_clk);
        @(negedge i_clk);
        check("drain", q_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
